booth_ctrl: RTL and testbench

BOOTH_CTRL -- requirements
Module: booth_ctrl

---
 rtl/mult_pkg.sv | 13 +
 rtl/booth_ctrl.sv | 67 ++++++
 tb/tb_booth_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: control bundle and FSM state types shared by the Booth multiplier
// datapath (mult) and its sequencer (booth_ctrl).
package mult_pkg;
  typedef struct packed {
    logic load_A;
    logic load_B;
    logic load_add;
    logic shift_HQ_LQ_Q_1;
    logic add_sub;
  } mult_control_t;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CHECK, SHIFT, DONE} state_t;
endpackage

// File: rtl/booth_ctrl.sv
// booth_ctrl: radix-2 Booth sequencer; one CHECK/SHIFT pair per operand bit,
// 2N+3 cycles from accepted start to the done pulse.
module booth_ctrl
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    Q_LSB,
  output mult_control_t mult_control,
  output logic          dp_clr,
  output logic          busy,
  output logic          done
);
  localparam int CW = $clog2(N + 1);
  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  assign cnt_inc = cnt + 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    mult_control = '0;
    dp_clr       = 1'b0;
    done         = 1'b0;
    busy         = state != IDLE;
    case (state)
      IDLE:  state_next = start ? CLEAR : IDLE;
      CLEAR: begin
        dp_clr     = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        mult_control.load_A = 1'b1;
        mult_control.load_B = 1'b1;
        cnt_next            = '0;
        state_next          = CHECK;
      end
      // 01 subtracts M, 10 adds M, 00/11 leaves HQ alone
      CHECK: begin
        mult_control.load_add = Q_LSB[1] ^ Q_LSB[0];
        mult_control.add_sub  = Q_LSB == 2'b01;
        state_next            = SHIFT;
      end
      SHIFT: begin
        mult_control.shift_HQ_LQ_Q_1 = 1'b1;
        cnt_next                     = cnt_inc;
        state_next                   = cnt_inc == CW'(N) ? DONE : CHECK;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: drives booth_ctrl with a behavioural Booth datapath and checks
// every cycle's control outputs and every product against a countdown reference.
module tb_booth_ctrl;
  import mult_pkg::*;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst, start;
  logic [N-1:0] a, b;
  logic [1:0] q_lsb;
  mult_control_t ctl;
  logic dp_clr, busy, done;
  int n_chk = 0, n_fail = 0, n_clr = 0, accepts = 0, left = 0;
  logic [2*N-1:0] exp_q[$];
  logic [N:0] hq;
  logic [N-1:0] lq, m;
  logic q1;

  booth_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .Q_LSB(q_lsb),
    .mult_control(ctl), .dp_clr(dp_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // HQ carries a guard bit so a multiplicand of -2^(N-1) subtracts exactly
  assign q_lsb = {q1, lq[0]};
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hq <= '0; lq <= '0; m <= '0; q1 <= 1'b0;
    end else begin
      if (dp_clr) begin hq <= '0; q1 <= 1'b0; end
      if (ctl.load_A) m <= a;
      if (ctl.load_B) lq <= b;
      if (ctl.load_add) hq <= ctl.add_sub ? hq - {m[N-1], m} : hq + {m[N-1], m};
      if (ctl.shift_HQ_LQ_Q_1) {hq, lq, q1} <= {hq[N], hq, lq};
    end
  end

  function automatic logic [2*N-1:0] prod(input logic [N-1:0] x, input logic [N-1:0] y);
    logic signed [2*N-1:0] r;
    r = $signed(x) * $signed(y);
    return r;
  endfunction

  // left counts cycles remaining in the operation: 2N+3 is the first busy cycle, 1 the done cycle
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      left <= 0;
      exp_q.delete();
    end else if (left == 0) begin
      if (start) begin
        left <= 2*N + 3;
        exp_q.push_back(prod(a, b));
        accepts <= accepts + 1;
      end
    end else left <= left - 1;
  end

  function automatic logic [7:0] exp_out(input int l, input logic [1:0] ql);
    logic chk, sh;
    chk = l >= 3 && l <= 2*N + 1 && l % 2 == 1;
    sh  = l >= 2 && l <= 2*N && l % 2 == 0;
    return {l > 0, l == 1, l == 2*N + 3, l == 2*N + 2, l == 2*N + 2,
            chk && (ql[1] ^ ql[0]), sh, chk && ql == 2'b01};
  endfunction

  always @(negedge clk) begin
    logic [7:0] got, want;
    logic [2*N-1:0] e;
    got  = {busy, done, dp_clr, ctl};
    want = exp_out(left, q_lsb);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL ctrl t=%0t {busy,done,clr,lA,lB,add,sh,sub} got %b want %b", $time, got, want);
    end
    if (dp_clr) n_clr++;
    if (done) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result t=%0t done with no expected operation", $time);
      end else begin
        e = exp_q.pop_front();
        if ({hq[N-1:0], lq} !== e) begin
          n_fail++;
          $display("FAIL result t=%0t Y got %h want %h", $time, {hq[N-1:0], lq}, e);
        end
      end
    end
  end

  task automatic wait_left(input int v);
    int k = 0;
    @(negedge clk);
    while (left != v && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (left != v) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout waiting for left=%0d, at %0d", v, left);
    end
  endtask

  task automatic op(input int x, input int y);
    wait_left(0);
    a = N'(x);
    b = N'(y);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int k, base;
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    op(3, 4);
    op(-7, 5);
    op(-128, -128);
    op(0, -1);
    op(5, 0);
    op(12, -3);
    op(-1, -1);
    wait_left(0);
    a = N'(6); b = N'(-7); start = 1'b1;
    base = accepts;
    k = 0;
    while (accepts < base + 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    n_chk++;
    if (accepts != base + 3) begin
      n_fail++;
      $display("FAIL held_start accepts got %0d want %0d", accepts - base, 3);
    end
    repeat (25) begin
      wait_left(0);
      a = N'($urandom());
      b = N'($urandom());
      start = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    op(3, 4);
    wait_left(10);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, dp_clr, ctl} !== 8'b0) begin
      n_fail++;
      $display("FAIL async_reset outputs got %b want 0", {busy, done, dp_clr, ctl});
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    op(3, 4);
    wait_left(0);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    n_chk++;
    if (n_clr != accepts) begin
      n_fail++;
      $display("FAIL dp_clr_count got %0d want %0d", n_clr, accepts);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
